// File: rtl/tlb_op_ctrl_if.sv
// Request/response channel between the MEM stage / CSR file and tlb_op_ctrl.
//   req_*  : op request handshake (valid/ready) with op and INVTLB operands
//   rsp_*  : one-cycle completion pulse (rsp_valid) plus held result fields
// master = MEM/CSR side, slave = tlb_op_ctrl.
interface tlb_op_ctrl_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IW = $clog2(TLBNUM);

  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [4:0]    req_inv_op;
  logic [9:0]    req_inv_asid;
  logic [18:0]   req_inv_vppn;

  logic          rsp_valid;
  logic [2:0]    rsp_op;
  logic          rsp_found;
  logic [IW-1:0] rsp_index;
  logic [88:0]   rsp_entry;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
    input  req_ready, rsp_valid, rsp_op, rsp_found, rsp_index, rsp_entry, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
    output req_ready, rsp_valid, rsp_op, rsp_found, rsp_index, rsp_entry, rsp_err
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences TLB maintenance ops (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) onto the TLB.
// One op in flight: IDLE -> EXEC -> RESP -> IDLE.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   bus (slave)         request handshake from MEM stage, response to CSR file
//   csr_*               CSR values snapshotted on accept
//   tlb_we/w_index/w_entry   TLB write port (strobe high for the EXEC cycle only)
//   tlb_r_index/r_entry      TLB read port
//   tlb_s_vppn/s_asid/s_found/s_index  search port 1 (also carries INVTLB operands)
//   tlb_inv_valid/inv_op     INVTLB strobe
module tlb_op_ctrl #(
  parameter int unsigned TLBNUM = 16,
  localparam int unsigned IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  tlb_op_ctrl_if.slave  bus,
  input  logic          flush,
  input  logic [31:0]   csr_tlbidx,
  input  logic [18:0]   csr_tlbehi_vppn,
  input  logic [9:0]    csr_asid,
  input  logic [31:0]   csr_tlbelo0,
  input  logic [31:0]   csr_tlbelo1,
  input  logic          csr_tlbrefill,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic [88:0]   tlb_w_entry,
  output logic [IW-1:0] tlb_r_index,
  input  logic [88:0]   tlb_r_entry,
  output logic [18:0]   tlb_s_vppn,
  output logic [9:0]    tlb_s_asid,
  input  logic          tlb_s_found,
  input  logic [IW-1:0] tlb_s_index,
  output logic          tlb_inv_valid,
  output logic [4:0]    tlb_inv_op
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [2:0] OpSrch = 3'd0;
  localparam logic [2:0] OpRd   = 3'd1;
  localparam logic [2:0] OpWr   = 3'd2;
  localparam logic [2:0] OpFill = 3'd3;
  localparam logic [2:0] OpInv  = 3'd4;

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q;
  logic          err_q;
  logic          flushed_q;
  logic [IW-1:0] fill_ctr_q;

  logic          rsp_found_q;
  logic [IW-1:0] rsp_index_q;
  logic [88:0]   rsp_entry_q;
  logic [2:0]    rsp_op_q;
  logic          rsp_err_q;

  logic          accept;
  logic          illegal;
  logic [88:0]   new_entry;

  assign accept = (state_q == StIdle) && bus.req_valid;

  // INVTLB ops above 6 are as illegal as undefined op codes.
  assign illegal = (bus.req_op > OpInv) || ((bus.req_op == OpInv) && (bus.req_inv_op > 5'd6));

  // E is forced on during refill handling, otherwise it is the inverse of TLBIDX.NE.
  assign new_entry = {
    csr_tlbrefill | ~csr_tlbidx[31],
    csr_tlbehi_vppn,
    csr_tlbidx[29:24],
    csr_asid,
    csr_tlbelo0[6] & csr_tlbelo1[6],
    csr_tlbelo0[27:8], csr_tlbelo0[3:2], csr_tlbelo0[5:4], csr_tlbelo0[1], csr_tlbelo0[0],
    csr_tlbelo1[27:8], csr_tlbelo1[3:2], csr_tlbelo1[5:4], csr_tlbelo1[1], csr_tlbelo1[0]
  };

  logic unused_csr_bits;
  assign unused_csr_bits = ^{csr_tlbidx[30], csr_tlbidx[23:IW], csr_tlbelo0[31:28],
                             csr_tlbelo0[7], csr_tlbelo1[31:28], csr_tlbelo1[7]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // TLB-facing outputs are registered on accept, so they double as the CSR snapshot for EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      fill_ctr_q    <= '0;
      op_q          <= '0;
      err_q         <= 1'b0;
      flushed_q     <= 1'b0;
      tlb_we        <= 1'b0;
      tlb_inv_valid <= 1'b0;
      tlb_w_index   <= '0;
      tlb_w_entry   <= '0;
      tlb_r_index   <= '0;
      tlb_s_vppn    <= '0;
      tlb_s_asid    <= '0;
      tlb_inv_op    <= '0;
      rsp_found_q   <= 1'b0;
      rsp_index_q   <= '0;
      rsp_entry_q   <= '0;
      rsp_op_q      <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_ctr_q    <= fill_ctr_q + 1'b1;
      tlb_we        <= 1'b0;
      tlb_inv_valid <= 1'b0;
      if (accept) begin
        op_q          <= bus.req_op;
        err_q         <= illegal;
        flushed_q     <= 1'b0;
        tlb_we        <= ~illegal && ((bus.req_op == OpWr) || (bus.req_op == OpFill));
        tlb_inv_valid <= ~illegal && (bus.req_op == OpInv);
        tlb_w_index   <= (bus.req_op == OpFill) ? fill_ctr_q : csr_tlbidx[IW-1:0];
        tlb_w_entry   <= new_entry;
        tlb_r_index   <= csr_tlbidx[IW-1:0];
        tlb_s_vppn    <= (bus.req_op == OpInv) ? bus.req_inv_vppn : csr_tlbehi_vppn;
        tlb_s_asid    <= (bus.req_op == OpInv) ? bus.req_inv_asid : csr_asid;
        tlb_inv_op    <= bus.req_inv_op;
      end
      if (state_q == StExec) begin
        flushed_q   <= flush;
        rsp_op_q    <= op_q;
        rsp_err_q   <= err_q;
        rsp_found_q <= (op_q == OpSrch) ? tlb_s_found :
                       (op_q == OpRd)   ? tlb_r_entry[88] : 1'b0;
        rsp_index_q <= (op_q == OpSrch) ? tlb_s_index : '0;
        rsp_entry_q <= ((op_q == OpRd) && tlb_r_entry[88]) ? tlb_r_entry : '0;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  // A flush seen in EXEC (latched) or during RESP itself kills the pulse.
  assign bus.rsp_valid = (state_q == StResp) && ~flushed_q && ~flush;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_found = rsp_found_q;
  assign bus.rsp_index = rsp_index_q;
  assign bus.rsp_entry = rsp_entry_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;
  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tlb_op_ctrl_if #(.TLBNUM(TLBNUM)) bus();

  logic          flush;
  logic [31:0]   csr_tlbidx;
  logic [18:0]   csr_tlbehi_vppn;
  logic [9:0]    csr_asid;
  logic [31:0]   csr_tlbelo0;
  logic [31:0]   csr_tlbelo1;
  logic          csr_tlbrefill;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_index;
  logic [88:0]   tlb_w_entry;
  logic [IW-1:0] tlb_r_index;
  logic [88:0]   tlb_r_entry;
  logic [18:0]   tlb_s_vppn;
  logic [9:0]    tlb_s_asid;
  logic          tlb_s_found;
  logic [IW-1:0] tlb_s_index;
  logic          tlb_inv_valid;
  logic [4:0]    tlb_inv_op;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .flush          (flush),
    .csr_tlbidx     (csr_tlbidx),
    .csr_tlbehi_vppn(csr_tlbehi_vppn),
    .csr_asid       (csr_asid),
    .csr_tlbelo0    (csr_tlbelo0),
    .csr_tlbelo1    (csr_tlbelo1),
    .csr_tlbrefill  (csr_tlbrefill),
    .tlb_we         (tlb_we),
    .tlb_w_index    (tlb_w_index),
    .tlb_w_entry    (tlb_w_entry),
    .tlb_r_index    (tlb_r_index),
    .tlb_r_entry    (tlb_r_entry),
    .tlb_s_vppn     (tlb_s_vppn),
    .tlb_s_asid     (tlb_s_asid),
    .tlb_s_found    (tlb_s_found),
    .tlb_s_index    (tlb_s_index),
    .tlb_inv_valid  (tlb_inv_valid),
    .tlb_inv_op     (tlb_inv_op)
  );

  // Minimal TLB: storage written by tlb_we, combinational read and search.
  logic [88:0] mem [TLBNUM];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) mem[i] <= '0;
    end else if (tlb_we) begin
      mem[tlb_w_index] <= tlb_w_entry;
    end
  end
  always_comb tlb_r_entry = mem[tlb_r_index];
  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (mem[i][88] && (mem[i][87:69] == tlb_s_vppn) &&
          (mem[i][52] || (mem[i][62:53] == tlb_s_asid))) begin
        tlb_s_found = 1'b1;
        tlb_s_index = i[IW-1:0];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // WR entry hand-packed from the CSR values used in test_wr.
  logic [88:0] exp_wr;
  assign exp_wr = {1'b1, 19'h01234, 6'd12, 10'h02A, 1'b1,
                   20'hABCDE, 2'd0, 2'd1, 1'b1, 1'b1,
                   20'h12345, 2'd3, 2'd0, 1'b0, 1'b1};

  task automatic send(input logic [2:0] op, input logic [4:0] iop,
                      input logic [9:0] iasid, input logic [18:0] ivppn);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_inv_op   = iop;
    bus.req_inv_asid = iasid;
    bus.req_inv_vppn = ivppn;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    checks++; if (tlb_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", tlb_we); end
    checks++; if (tlb_inv_valid !== 1'b0) begin errors++; $display("FAIL rst_inv got %b want 0", tlb_inv_valid); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_entry !== 89'd0) begin errors++; $display("FAIL rst_rsp_entry got %h want 0", bus.rsp_entry); end
    checks++; if (tlb_w_index !== 4'd0) begin errors++; $display("FAIL rst_w_index got %0d want 0", tlb_w_index); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wr;
    csr_tlbidx = 32'h0C00_0005; csr_tlbehi_vppn = 19'h01234; csr_asid = 10'h02A;
    csr_tlbelo0 = 32'h0ABC_DE53; csr_tlbelo1 = 32'h0123_454D; csr_tlbrefill = 1'b0;
    send(3'd2, 5'd0, 10'd0, 19'd0);
    csr_tlbidx = 32'h0C00_0003;  // must not affect the op already accepted
    #1;
    checks++; if (tlb_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", tlb_we); end
    checks++; if (tlb_w_index !== 4'd5) begin errors++; $display("FAIL wr_index got %0d want 5", tlb_w_index); end
    checks++; if (tlb_w_entry !== exp_wr) begin errors++; $display("FAIL wr_entry got %h want %h", tlb_w_entry, exp_wr); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_exec got %b want 0", bus.req_ready); end
    step;
    checks++; if (tlb_we !== 1'b0) begin errors++; $display("FAIL wr_we_resp got %b want 0", tlb_we); end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_op !== 3'd2 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_op got %0d/%b want 2/0", bus.rsp_op, bus.rsp_err); end
    step;
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_idle got ready %b valid %b want 1 0", bus.req_ready, bus.rsp_valid); end
    // Index 9 written with NE=1 and no refill: stored with E=0.
    csr_tlbidx = 32'h8C00_0009;
    send(3'd2, 5'd0, 10'd0, 19'd0);
    checks++; if (tlb_w_entry[88] !== 1'b0 || tlb_w_index !== 4'd9) begin errors++; $display("FAIL wr_ne got e %b idx %0d want 0 9", tlb_w_entry[88], tlb_w_index); end
    step; step;
  endtask

  task automatic test_srch;
    csr_tlbehi_vppn = 19'h01234;
    send(3'd0, 5'd0, 10'd0, 19'd0);
    checks++; if (tlb_s_vppn !== 19'h01234 || tlb_s_asid !== 10'h02A) begin errors++; $display("FAIL srch_port got %h/%h want 1234/2a", tlb_s_vppn, tlb_s_asid); end
    step;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_found !== 1'b1 || bus.rsp_index !== 4'd5) begin errors++; $display("FAIL srch_hit got v%b f%b i%0d want 1 1 5", bus.rsp_valid, bus.rsp_found, bus.rsp_index); end
    step;
    csr_tlbehi_vppn = 19'h00777;
    send(3'd0, 5'd0, 10'd0, 19'd0);
    step;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_found !== 1'b0) begin errors++; $display("FAIL srch_miss got v%b f%b want 1 0", bus.rsp_valid, bus.rsp_found); end
    step;
  endtask

  task automatic test_rd;
    csr_tlbidx = 32'h0C00_0005;
    send(3'd1, 5'd0, 10'd0, 19'd0);
    checks++; if (tlb_r_index !== 4'd5) begin errors++; $display("FAIL rd_index got %0d want 5", tlb_r_index); end
    step;
    checks++; if (bus.rsp_found !== 1'b1 || bus.rsp_entry !== exp_wr) begin errors++; $display("FAIL rd_hit got f%b %h want 1 %h", bus.rsp_found, bus.rsp_entry, exp_wr); end
    step;
    csr_tlbidx = 32'h0C00_0009;
    send(3'd1, 5'd0, 10'd0, 19'd0);
    step;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_found !== 1'b0 || bus.rsp_entry !== 89'd0) begin errors++; $display("FAIL rd_e0 got v%b f%b %h want 1 0 0", bus.rsp_valid, bus.rsp_found, bus.rsp_entry); end
    step;
  endtask

  task automatic test_inv;
    send(3'd4, 5'd5, 10'h010, 19'h01234);
    checks++; if (tlb_inv_valid !== 1'b1 || tlb_we !== 1'b0) begin errors++; $display("FAIL inv_strobe got inv%b we%b want 1 0", tlb_inv_valid, tlb_we); end
    checks++; if (tlb_inv_op !== 5'd5 || tlb_s_vppn !== 19'h01234 || tlb_s_asid !== 10'h010) begin errors++; $display("FAIL inv_fields got %0d %h %h want 5 1234 10", tlb_inv_op, tlb_s_vppn, tlb_s_asid); end
    step;
    checks++; if (tlb_inv_valid !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL inv_resp got inv%b v%b e%b want 0 1 0", tlb_inv_valid, bus.rsp_valid, bus.rsp_err); end
    step;
    send(3'd4, 5'd7, 10'h010, 19'h01234);
    checks++; if (tlb_inv_valid !== 1'b0) begin errors++; $display("FAIL inv7_strobe got %b want 0", tlb_inv_valid); end
    step;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_op !== 3'd4) begin errors++; $display("FAIL inv7_err got v%b e%b op%0d want 1 1 4", bus.rsp_valid, bus.rsp_err, bus.rsp_op); end
    step;
    send(3'd6, 5'd0, 10'd0, 19'd0);
    checks++; if (tlb_we !== 1'b0 || tlb_inv_valid !== 1'b0) begin errors++; $display("FAIL op6_strobe got we%b inv%b want 0 0", tlb_we, tlb_inv_valid); end
    step;
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_op !== 3'd6) begin errors++; $display("FAIL op6_err got e%b op%0d want 1 6", bus.rsp_err, bus.rsp_op); end
    step;
  endtask

  task automatic test_back_to_back;
    logic [IW-1:0] first_idx;
    logic [IW-1:0] diff;
    csr_tlbidx = 32'h8C00_0000; csr_tlbrefill = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd3;
    step;
    first_idx = tlb_w_index;
    checks++; if (tlb_we !== 1'b1 || tlb_w_entry[88] !== 1'b1) begin errors++; $display("FAIL fill1 got we%b e%b want 1 1", tlb_we, tlb_w_entry[88]); end
    step;
    checks++; if (bus.req_ready !== 1'b0 || tlb_we !== 1'b0) begin errors++; $display("FAIL fill_resp got ready%b we%b want 0 0", bus.req_ready, tlb_we); end
    step;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL fill_n3_ready got %b want 1", bus.req_ready); end
    step;
    bus.req_valid = 1'b0;
    diff = tlb_w_index - first_idx;
    checks++; if (tlb_we !== 1'b1 || diff !== 4'd3) begin errors++; $display("FAIL fill2 got we%b diff %0d want 1 3", tlb_we, diff); end
    step; step;
    csr_tlbrefill = 1'b0;
  endtask

  task automatic test_flush;
    csr_tlbehi_vppn = 19'h01234; csr_tlbidx = 32'h0C00_0005;
    send(3'd0, 5'd0, 10'd0, 19'd0);
    step;
    flush = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp got %b want 0", bus.rsp_valid); end
    step;
    flush = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", bus.req_ready); end
    send(3'd0, 5'd0, 10'd0, 19'd0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_exec got %b want 0", bus.rsp_valid); end
    step;
    @(negedge clk);
    flush = 1'b1;  // flush while idle must not affect the next op
    send(3'd0, 5'd0, 10'd0, 19'd0);
    flush = 1'b0;
    step;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_found !== 1'b1) begin errors++; $display("FAIL flush_idle got v%b f%b want 1 1", bus.rsp_valid, bus.rsp_found); end
    step;
  endtask

  task automatic test_reset_exec;
    csr_tlbidx = 32'h0C00_0005;
    send(3'd2, 5'd0, 10'd0, 19'd0);
    checks++; if (tlb_we !== 1'b1) begin errors++; $display("FAIL rstx_we_pre got %b want 1", tlb_we); end
    #1 reset = 1'b1;
    #1;
    checks++; if (tlb_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstx_drop got we%b ready%b v%b want 0 1 0", tlb_we, bus.req_ready, bus.rsp_valid); end
    @(negedge clk);
    reset = 1'b0;
    step;
    checks++; if (bus.rsp_valid !== 1'b0 || tlb_we !== 1'b0) begin errors++; $display("FAIL rstx_after got v%b we%b want 0 0", bus.rsp_valid, tlb_we); end
    step;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_inv_op = '0;
    bus.req_inv_asid = '0; bus.req_inv_vppn = '0;
    flush = 1'b0; csr_tlbidx = '0; csr_tlbehi_vppn = '0; csr_asid = '0;
    csr_tlbelo0 = '0; csr_tlbelo1 = '0; csr_tlbrefill = 1'b0;
    test_reset;
    test_wr;
    test_srch;
    test_rd;
    test_inv;
    test_back_to_back;
    test_flush;
    test_reset_exec;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
